// File: rtl/fp_addsub_sequencer_if.sv
// Datapath handshake bundle between the add/sub sequencer and the FP datapath.
// master = sequencer side, slave = datapath side.
`timescale 1ns/1ps
interface fp_addsub_sequencer_if;
    logic        dp_start;
    logic        dp_op;
    logic [31:0] dp_a;
    logic [31:0] dp_b;
    logic        dp_done;
    logic [31:0] dp_result;

    modport master (
        output dp_start, dp_op, dp_a, dp_b,
        input  dp_done, dp_result
    );

    modport slave (
        input  dp_start, dp_op, dp_a, dp_b,
        output dp_done, dp_result
    );
endinterface

// File: rtl/fp_addsub_sequencer.sv
// Operator controller for the FP add/sub datapath: byte-wise operand load,
// start/done handshake, timeout, result latch and status LEDs.
// Optional macro FP_SPECIAL_BYPASS_EN: Inf/NaN operands skip the datapath.
`timescale 1ns/1ps
module fp_addsub_sequencer #(
    parameter int DIV_WIDTH      = 24,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mode,
    input  logic                  step,
    input  logic                  save,
    input  logic                  start,
    input  logic                  selnum,
    input  logic [1:0]            seldata,
    input  logic [7:0]            datain,
    input  logic                  op_sel,
    fp_addsub_sequencer_if.master dp,
    output logic [31:0]           result,
    output logic                  result_valid,
    output logic                  busy,
    output logic                  err,
    output logic [3:0]            leds
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t                 state;
    logic [2:0]             save_s;
    logic [2:0]             step_s;
    logic [2:0]             start_s;
    logic                   save_p;
    logic                   step_p;
    logic                   start_p;
    logic [DIV_WIDTH-1:0]   div;
    logic                   tick;
    logic [TW-1:0]          tcnt;
    logic [TW-1:0]          tcnt_inc;
    logic [31:0]            a_q;
    logic [31:0]            b_q;
    logic                   op_q;
    logic                   start_q;

    // Two-flop synchronizers plus a history flop for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            save_s  <= 3'b000;
            step_s  <= 3'b000;
            start_s <= 3'b000;
        end else begin
            save_s  <= {save_s[1:0], save};
            step_s  <= {step_s[1:0], step};
            start_s <= {start_s[1:0], start};
        end
    end

    assign save_p  = save_s[1] & ~save_s[2];
    assign step_p  = step_s[1] & ~step_s[2];
    assign start_p = start_s[1] & ~start_s[2];

    // Free-running divider for the auto-step clock enable
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    assign tick     = mode ? step_p : (&div);
    assign tcnt_inc = tcnt + 1'b1;

`ifdef FP_SPECIAL_BYPASS_EN
    logic special;
    assign special = (&a_q[30:23]) | (&b_q[30:23]);
`endif

    // Sequencer FSM with registered handshake, status and operand registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= 1'b0;
            start_q      <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
            leds         <= 4'b0001;
            tcnt         <= '0;
        end else begin
            start_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (save_p) begin
                        if (selnum) b_q[{seldata, 3'b000} +: 8] <= datain;
                        else        a_q[{seldata, 3'b000} +: 8] <= datain;
                    end
                    if (start_p) begin
                        op_q         <= op_sel;
                        result_valid <= 1'b0;
                        state        <= S_ISSUE;
                        busy         <= 1'b1;
                        leds         <= 4'b0010;
                    end
                end
                S_ISSUE: begin
                    if (tick) begin
`ifdef FP_SPECIAL_BYPASS_EN
                        if (special) begin
                            result       <= 32'h7FC0_0000;
                            result_valid <= 1'b1;
                            state        <= S_DONE;
                            busy         <= 1'b0;
                            leds         <= 4'b1000;
                        end else
`endif
                        begin
                            start_q <= 1'b1;
                            tcnt    <= '0;
                            state   <= S_WAIT;
                            leds    <= 4'b0100;
                        end
                    end
                end
                S_WAIT: begin
                    if (dp.dp_done) begin
                        result       <= dp.dp_result;
                        result_valid <= 1'b1;
                        state        <= S_DONE;
                        busy         <= 1'b0;
                        leds         <= 4'b1000;
                    end else if (tcnt_inc == TW'(TIMEOUT_CYCLES)) begin
                        tcnt  <= tcnt_inc;
                        err   <= 1'b1;
                        state <= S_ERR;
                        busy  <= 1'b0;
                        leds  <= 4'b1111;
                    end else begin
                        tcnt <= tcnt_inc;
                    end
                end
                S_DONE: begin
                    if (tick) begin
                        state <= S_IDLE;
                        leds  <= 4'b0001;
                    end
                end
                S_ERR: begin
                    if (start_p) begin
                        err   <= 1'b0;
                        state <= S_IDLE;
                        leds  <= 4'b0001;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    leds  <= 4'b0001;
                end
            endcase
        end
    end

    assign dp.dp_start = start_q;
    assign dp.dp_op    = op_q;
    assign dp.dp_a     = a_q;
    assign dp.dp_b     = b_q;
endmodule
